// File: rtl/stack_pkg.sv
// Shared op codes, FSM state encoding and op legality helper for stack_req_issuer.
package stack_pkg;

    localparam logic [2:0] OP_PUSH   = 3'd0;
    localparam logic [2:0] OP_POP    = 3'd1;
    localparam logic [2:0] OP_TOP    = 3'd2;
    localparam logic [2:0] OP_POPOUT = 3'd3;
    localparam logic [2:0] OP_SEARCH = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] o);
        return (o <= OP_SEARCH);
    endfunction

endpackage

// File: rtl/stack_req_issuer_if.sv
// Client-side and stack-unit-side signal bundle for stack_req_issuer.
interface stack_req_issuer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic             rdy;
    logic [2:0]       op;
    logic [WIDTH-1:0] datain;
    logic             ack;
    logic [WIDTH-1:0] dataout;
    logic             esito;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_esito;
    logic             res_timeout;

    modport slave (
        input  in_valid, in_op, in_data, ack, dataout, esito,
        output in_ready, rdy, op, datain, res_valid, res_data, res_esito, res_timeout
    );

    modport master (
        output in_valid, in_op, in_data, ack, dataout, esito,
        input  in_ready, rdy, op, datain, res_valid, res_data, res_esito, res_timeout
    );
endinterface

// File: rtl/stack_req_issuer_fifo.sv
// req_fifo: DEPTH-entry request queue with registered count and wrapping pointers.
module req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 35
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so power-of-two wrap is implicit.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/stack_req_issuer.sv
// Queues client stack requests and issues them one at a time to the stack unit.
// Optional ack timeout enabled by defining STACK_REQ_TIMEOUT_EN.
module stack_req_issuer
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clock,
    input logic               reset,
    stack_req_issuer_if.slave bus
);
    localparam int unsigned EW = 3 + WIDTH;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_params
        $error("stack_req_issuer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    logic             push, pop, full, empty;
    logic [EW-1:0]    head;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] head_data;
    logic             timeout_hit;

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] datain_q, datain_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_esito_q, res_esito_d;

    assign {head_op, head_data} = head;
    assign push                 = bus.in_valid & ~full;

    req_fifo #(.DEPTH(DEPTH), .DW(EW)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data ({bus.in_op, bus.in_data}),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        op_d        = op_q;
        datain_d    = datain_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_esito_d = res_esito_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (op_legal(head_op)) begin
                        state_d  = ISSUE;
                        rdy_d    = 1'b1;
                        op_d     = head_op;
                        datain_d = head_data;
                    end else begin
                        pop         = 1'b1;
                        res_valid_d = 1'b1;
                        res_esito_d = 1'b0;
                        res_data_d  = '0;
                    end
                end
            end
            ISSUE: begin
                if (bus.ack) begin
                    pop         = 1'b1;
                    res_valid_d = 1'b1;
                    res_data_d  = bus.dataout;
                    res_esito_d = bus.esito;
                    rdy_d       = 1'b0;
                    state_d     = GAP;
                end else if (timeout_hit) begin
                    pop         = 1'b1;
                    res_valid_d = 1'b1;
                    res_data_d  = '0;
                    res_esito_d = 1'b0;
                    rdy_d       = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            op_q        <= '0;
            datain_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_esito_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            op_q        <= op_d;
            datain_q    <= datain_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_esito_q <= res_esito_d;
        end
    end

`ifdef STACK_REQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          res_timeout_q, res_timeout_d;

    // Counter reads 0 in the first ISSUE cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
    assign timeout_hit = (state_q == ISSUE) && (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d     = (state_q == ISSUE) ? tmo_cnt_q + TW'(1) : '0;
        res_timeout_d = res_valid_d ? (timeout_hit & ~bus.ack) : res_timeout_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign bus.res_timeout = res_timeout_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.res_timeout = 1'b0;
`endif

    assign bus.in_ready  = ~full;
    assign bus.rdy       = rdy_q;
    assign bus.op        = op_q;
    assign bus.datain    = datain_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_esito = res_esito_q;
endmodule
